// File: rtl/pcie_drp_arbiter.sv
// Round-robin arbiter sharing one PCIE_2_1 DRP port between N_REQ requesters.
// Sequences each access as a one-cycle DRPEN pulse followed by a bounded wait for DRPRDY.
module pcie_drp_arbiter #(
  parameter int N_REQ          = 2,
  parameter int ADDR_W         = 9,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      sys_rst_n,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ-1:0]          req_we,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          req_ready,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic                      err_stray,
  output logic                      drp_en,
  output logic                      drp_we,
  output logic [ADDR_W-1:0]         drp_addr,
  output logic [DATA_W-1:0]         drp_di,
  input  logic                      drp_rdy,
  input  logic [DATA_W-1:0]         drp_do,
  output logic [1:0]                dbg_state
);

  // Handshake: a requester holds req_valid until a one-cycle req_ready pulse;
  // completion is a one-cycle rsp_valid pulse on the same index, with
  // rsp_timeout/rsp_rdata qualified by it. Both vectors are at most one-hot.

  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [CW-1:0]       r_cnt, w_cnt_nxt;
  logic [GW-1:0]       r_last_grant, w_last_nxt;
  logic [N_REQ-1:0]    r_req_ready, w_req_ready_nxt;
  logic [N_REQ-1:0]    r_rsp_valid, w_rsp_valid_nxt;
  logic [DATA_W-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic                r_rsp_timeout, w_rsp_timeout_nxt;
  logic                r_busy, w_busy_nxt;
  logic                r_err_stray, w_err_nxt;
  logic                r_drp_en, w_drp_en_nxt;
  logic                r_drp_we, w_drp_we_nxt;
  logic [ADDR_W-1:0]   r_drp_addr, w_drp_addr_nxt;
  logic [DATA_W-1:0]   r_drp_di, w_drp_di_nxt;
  logic                w_win_found;
  logic [GW-1:0]       w_win_idx;

  function automatic logic [GW-1:0] wrap_idx(input logic [GW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= N_REQ) s = s - N_REQ;
    return GW'(s);
  endfunction

  // Search starts one past the last grant so every requester gets a turn.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!w_win_found && req_valid[wrap_idx(r_last_grant, k)]) begin
        w_win_found = 1'b1;
        w_win_idx   = wrap_idx(r_last_grant, k);
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_last_nxt        = r_last_grant;
    w_req_ready_nxt   = '0;
    w_rsp_valid_nxt   = '0;
    w_rsp_timeout_nxt = 1'b0;
    w_rsp_rdata_nxt   = r_rsp_rdata;
    w_drp_en_nxt      = 1'b0;
    w_drp_we_nxt      = r_drp_we;
    w_drp_addr_nxt    = r_drp_addr;
    w_drp_di_nxt      = r_drp_di;
    w_err_nxt         = r_err_stray | (drp_rdy && (r_state != S_WAIT));
    case (r_state)
      S_IDLE: begin
        if (w_win_found) begin
          w_state_nxt                = S_ISSUE;
          w_last_nxt                 = w_win_idx;
          w_req_ready_nxt[w_win_idx] = 1'b1;
          w_drp_en_nxt               = 1'b1;
          w_drp_we_nxt               = req_we[w_win_idx];
          w_drp_addr_nxt             = req_addr[int'(w_win_idx)*ADDR_W +: ADDR_W];
          w_drp_di_nxt               = req_wdata[int'(w_win_idx)*DATA_W +: DATA_W];
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_WAIT;
        w_cnt_nxt   = '0;
      end
      S_WAIT: begin
        // A DRPRDY on the limit edge still counts as a normal completion.
        if (drp_rdy) begin
          w_state_nxt                  = S_IDLE;
          w_rsp_valid_nxt[r_last_grant] = 1'b1;
          w_rsp_rdata_nxt              = r_drp_we ? '0 : drp_do;
        end else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          w_state_nxt                  = S_IDLE;
          w_rsp_valid_nxt[r_last_grant] = 1'b1;
          w_rsp_timeout_nxt            = 1'b1;
          w_rsp_rdata_nxt              = '0;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_busy_nxt = (w_state_nxt != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!sys_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_last_grant  <= GW'(N_REQ - 1);
      r_req_ready   <= '0;
      r_rsp_valid   <= '0;
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
      r_busy        <= 1'b0;
      r_err_stray   <= 1'b0;
      r_drp_en      <= 1'b0;
      r_drp_we      <= 1'b0;
      r_drp_addr    <= '0;
      r_drp_di      <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_last_grant  <= w_last_nxt;
      r_req_ready   <= w_req_ready_nxt;
      r_rsp_valid   <= w_rsp_valid_nxt;
      r_rsp_rdata   <= w_rsp_rdata_nxt;
      r_rsp_timeout <= w_rsp_timeout_nxt;
      r_busy        <= w_busy_nxt;
      r_err_stray   <= w_err_nxt;
      r_drp_en      <= w_drp_en_nxt;
      r_drp_we      <= w_drp_we_nxt;
      r_drp_addr    <= w_drp_addr_nxt;
      r_drp_di      <= w_drp_di_nxt;
    end
  end

  assign req_ready   = r_req_ready;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_timeout = r_rsp_timeout;
  assign busy        = r_busy;
  assign err_stray   = r_err_stray;
  assign drp_en      = r_drp_en;
  assign drp_we      = r_drp_we;
  assign drp_addr    = r_drp_addr;
  assign drp_di      = r_drp_di;
  assign dbg_state   = r_state;

endmodule

// File: doc/pcie_drp_arbiter.md
Name: pcie_drp_arbiter

Overview:
Shares the single DRP port of the PCIE_2_1 hard block between N_REQ requesters, e.g. a boot-time config sequencer and a debug/UART poke path. It performs round-robin arbitration and sequences each DRP transaction: a one-cycle DRPEN, then a wait for DRPRDY, bounded by a timeout. It returns read data and status to the granted requester. It sits between board-level control logic and the PCIE_2_1 DRP pins, all in one clock domain (DRPCLK = clk).

Parameters:
N_REQ, 2, number of requesters (2..4)
ADDR_W, 9, DRP address width (PCIE_2_1 DRPADDR)
DATA_W, 16, DRP data width
TIMEOUT_CYCLES, 64, max cycles in WAIT before aborting (>=2)

Ports:
clk  in  1  system clock; also drives DRPCLK
sys_rst_n  in  1  synchronous active-low reset
req_valid  in  N_REQ  per-requester request, held until req_ready
req_we  in  N_REQ  1 = write, 0 = read
req_addr  in  N_REQ*ADDR_W  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  N_REQ*DATA_W  flattened write data
req_ready  out  N_REQ  one-cycle accept pulse, one-hot
rsp_valid  out  N_REQ  one-cycle completion pulse, one-hot
rsp_rdata  out  DATA_W  DRPDO captured on completion; 0 on timeout or write
rsp_timeout  out  1  qualifies rsp_valid: transaction timed out
busy  out  1  high in ISSUE and WAIT
err_stray  out  1  sticky: DRPRDY seen outside WAIT
drp_en  out  1  to DRPEN
drp_we  out  1  to DRPWE
drp_addr  out  ADDR_W  to DRPADDR
drp_di  out  DATA_W  to DRPDI
drp_rdy  in  1  from DRPRDY
drp_do  in  DATA_W  from DRPDO

Behaviour:
- Interface is fixed: one clock; reset is synchronous and active-low. Ports are clk and sys_rst_n.
- Reset, sampled at a rising clk edge with sys_rst_n = 0:
  - State goes to IDLE.
  - All outputs go to 0, including err_stray.
  - The round-robin pointer is set so requester 0 has highest priority.
- Reset mid-transaction aborts it. No rsp_valid is issued. A DRPRDY arriving after reset sets err_stray.
- All outputs are registered.
- States: IDLE, ISSUE, WAIT.
- IDLE:
  - If any req_valid is high at edge T, the winner is chosen round-robin: first valid index strictly after last_grant, wrapping.
  - The winner's we/addr/wdata are latched and last_grant is updated.
  - At T+1: state is ISSUE, req_ready[winner] = 1, drp_en = 1, and drp_we/drp_addr/drp_di are driven from the latches.
- ISSUE: lasts exactly one cycle, then WAIT with the timeout counter at 0.
  - drp_en is high only in ISSUE, and never again until the current transaction ends.
  - drp_addr/drp_di/drp_we hold their value until the next grant.
- WAIT, drp_rdy = 1 at edge W:
  - rsp_rdata is set to drp_do for a read, 0 for a write.
  - At W+1: rsp_valid[grant] = 1 and rsp_timeout = 0; state is back in IDLE.
  - A new arbitration may be sampled at W+1, so issue-to-issue minimum is 3 cycles.
- WAIT, no drp_rdy: the counter increments each cycle. When the counter = TIMEOUT_CYCLES-1 and drp_rdy = 0:
  - Next cycle: rsp_valid[grant] = 1, rsp_timeout = 1, rsp_rdata = 0.
  - State returns to IDLE.
- drp_rdy in WAIT on the same edge the counter hits its limit: completes normally (rdy wins).
- drp_rdy high in IDLE or ISSUE is ignored for data and sets err_stray. err_stray clears only on reset.
- Requesters drop req_valid after req_ready. A valid held high is treated as a new request at the next IDLE arbitration.
- req_valid deasserted before grant is legal; it is not latched.
- req_ready and rsp_valid are each at most one-hot and one cycle wide.

Test Plan:
- Single read: req_valid[0]=1, addr=9'h1A0 at T → req_ready[0], drp_en=1, drp_addr=9'h1A0, drp_we=0 at T+1. drp_rdy=1, drp_do=16'hBEEF three cycles later → rsp_valid[0]=1, rsp_rdata=16'hBEEF, rsp_timeout=0 the following cycle.
- Collision after reset: req_valid=2'b11 with req0 write addr 9'h010 data 16'h1234, req1 read addr 9'h020, drp_rdy after 2 cycles each → req0 granted first (drp_we=1, drp_di=16'h1234), then req1. Exactly 2 drp_en pulses; rsp_valid order 2'b01 then 2'b10.
- Fairness: both req_valid held high for 6 transactions → grants alternate 0,1,0,1,0,1. No requester is granted twice consecutively.
- Timeout: TIMEOUT_CYCLES=8, drp_rdy held low → rsp_valid with rsp_timeout=1 and rsp_rdata=0 exactly 8 WAIT cycles after ISSUE, then busy=0. A late drp_rdy 2 cycles later → err_stray=1.
- Reset mid-WAIT: sys_rst_n=0 for one cycle during WAIT → next cycle all outputs 0, no rsp_valid. A later drp_rdy sets err_stray. The next request is granted normally, with requester 0 priority.
- Same-edge rdy/limit: drp_rdy asserted exactly on the limit edge → rsp_timeout=0 and data is returned.
